d8m_read_scheduler: RTL and testbench

Timing and read-sequencing controller for the D8M camera-to-display RGB path. It generates the VGA_CLK-domain raster (HS, VS, X/Y counts) and the per-pixel READ_Request strobe that drains the camera frame FIFO into the line buffers and Bayer demosaic stage. It admits reads only on whole-frame boundaries once the camera side reports a frame ready. It detects FIFO underflow, aborts the frame and resynchronises at the next frame boundary.

---
 rtl/d8m_read_scheduler_pkg.sv | 23 ++
 rtl/d8m_read_scheduler_if.sv | 27 ++
 rtl/d8m_read_scheduler_raster_gen.sv | 68 ++++++
 rtl/d8m_read_scheduler.sv | 100 ++++++++++
 tb/tb_d8m_read_scheduler.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/d8m_read_scheduler_pkg.sv
// Shared types and default VGA 640x480@60 timing for the D8M read scheduler.
package d8m_pkg;

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned UFLOW_W = 8;

  localparam int unsigned D8M_H_ACT  = 640;
  localparam int unsigned D8M_H_FP   = 16;
  localparam int unsigned D8M_H_SYNC = 96;
  localparam int unsigned D8M_H_BP   = 48;
  localparam int unsigned D8M_V_ACT  = 480;
  localparam int unsigned D8M_V_FP   = 10;
  localparam int unsigned D8M_V_SYNC = 2;
  localparam int unsigned D8M_V_BP   = 33;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_RUN        = 2'd2,
    ST_RESYNC     = 2'd3
  } state_e;

endpackage

// File: rtl/d8m_read_scheduler_if.sv
// Camera-FIFO control and VGA raster bundle between the scheduler and its neighbours.
interface d8m_read_scheduler_if;
  import d8m_pkg::*;

  logic               iENABLE;
  logic               iFRAME_RDY;
  logic               iFIFO_EMPTY;
  logic               READ_Request;
  logic               VGA_HS;
  logic               VGA_VS;
  logic [CNT_W-1:0]   oX;
  logic [CNT_W-1:0]   oY;
  logic               oFRAME_START;
  logic               oUNDERFLOW;
  logic [UFLOW_W-1:0] oUFLOW_CNT;

  modport master (
    output iENABLE, iFRAME_RDY, iFIFO_EMPTY,
    input  READ_Request, VGA_HS, VGA_VS, oX, oY, oFRAME_START, oUNDERFLOW, oUFLOW_CNT
  );

  modport slave (
    input  iENABLE, iFRAME_RDY, iFIFO_EMPTY,
    output READ_Request, VGA_HS, VGA_VS, oX, oY, oFRAME_START, oUNDERFLOW, oUFLOW_CNT
  );

endinterface

// File: rtl/d8m_read_scheduler_raster_gen.sv
// Free-running h/v raster with registered sync decode and a FRAME_END strobe,
// all aligned to the cycle in which h_o/v_o hold the matching count.
module d8m_raster_gen
  import d8m_pkg::*;
#(
  parameter int unsigned H_ACT  = D8M_H_ACT,
  parameter int unsigned H_FP   = D8M_H_FP,
  parameter int unsigned H_SYNC = D8M_H_SYNC,
  parameter int unsigned H_BP   = D8M_H_BP,
  parameter int unsigned V_ACT  = D8M_V_ACT,
  parameter int unsigned V_FP   = D8M_V_FP,
  parameter int unsigned V_SYNC = D8M_V_SYNC,
  parameter int unsigned V_BP   = D8M_V_BP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             frame_end_o,
  output logic             act_next_c
);

  localparam int unsigned H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACT + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACT + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             hs_q, vs_q, fe_q;

  always_comb begin
    h_d = h_q + CNT_W'(1);
    v_d = v_q;
    if (h_q == CNT_W'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_q + CNT_W'(1);
    end
  end

  // Decode from the next count so the registered strobes line up with h_q/v_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      fe_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= !((h_d >= CNT_W'(HS_BEG)) && (h_d < CNT_W'(HS_END)));
      vs_q <= !((v_d >= CNT_W'(VS_BEG)) && (v_d < CNT_W'(VS_END)));
      fe_q <= (h_d == CNT_W'(H_TOTAL - 1)) && (v_d == CNT_W'(V_TOTAL - 1));
    end
  end

  assign act_next_c  = (h_d < CNT_W'(H_ACT)) && (v_d < CNT_W'(V_ACT));
  assign h_o         = h_q;
  assign v_o         = v_q;
  assign hs_o        = hs_q;
  assign vs_o        = vs_q;
  assign frame_end_o = fe_q;

endmodule

// File: rtl/d8m_read_scheduler.sv
// Frame-admission FSM, READ_Request gating and underflow tracking for the
// D8M camera-to-VGA path; raster timing comes from d8m_raster_gen.
module d8m_read_scheduler
  import d8m_pkg::*;
#(
  parameter int unsigned H_ACT  = D8M_H_ACT,
  parameter int unsigned H_FP   = D8M_H_FP,
  parameter int unsigned H_SYNC = D8M_H_SYNC,
  parameter int unsigned H_BP   = D8M_H_BP,
  parameter int unsigned V_ACT  = D8M_V_ACT,
  parameter int unsigned V_FP   = D8M_V_FP,
  parameter int unsigned V_SYNC = D8M_V_SYNC,
  parameter int unsigned V_BP   = D8M_V_BP
) (
  input  logic                 VGA_CLK,
  input  logic                 RESET_N,
  d8m_read_scheduler_if.slave  bus
);

  state_e             state_q, state_d;
  logic               frame_end, act_next_c, uflow_c, admit_c;
  logic               read_q, read_d;
  logic               fstart_q, fstart_d;
  logic               uflag_q, uflag_d;
  logic [UFLOW_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]   h, v;
  logic               hs, vs;

  d8m_raster_gen #(
    .H_ACT (H_ACT),  .H_FP (H_FP),  .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACT (V_ACT),  .V_FP (V_FP),  .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_raster (
    .clk_i       (VGA_CLK),
    .rst_ni      (RESET_N),
    .h_o         (h),
    .v_o         (v),
    .hs_o        (hs),
    .vs_o        (vs),
    .frame_end_o (frame_end),
    .act_next_c  (act_next_c)
  );

  assign uflow_c = read_q && bus.iFIFO_EMPTY;

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      read_q   <= 1'b0;
      fstart_q <= 1'b0;
      uflag_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      fstart_q <= fstart_d;
      uflag_q  <= uflag_d;
      cnt_q    <= cnt_d;
    end
  end

  // Disable overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (!bus.iENABLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:       state_d = ST_WAIT_FRAME;
        ST_WAIT_FRAME: if (frame_end && bus.iFRAME_RDY) state_d = ST_RUN;
        ST_RUN:        if (uflow_c) state_d = ST_RESYNC;
        ST_RESYNC:     if (frame_end) state_d = ST_WAIT_FRAME;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  // Underflow can only occur while already in RUN, so it never coincides with admission.
  always_comb begin
    admit_c  = (state_q == ST_WAIT_FRAME) && (state_d == ST_RUN);
    read_d   = (state_d == ST_RUN) && act_next_c;
    fstart_d = admit_c;
    uflag_d  = uflag_q;
    cnt_d    = cnt_q;
    if (admit_c) uflag_d = 1'b0;
    if (uflow_c) begin
      uflag_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + UFLOW_W'(1);
    end
  end

  assign bus.READ_Request = read_q;
  assign bus.VGA_HS       = hs;
  assign bus.VGA_VS       = vs;
  assign bus.oX           = h;
  assign bus.oY           = v;
  assign bus.oFRAME_START = fstart_q;
  assign bus.oUNDERFLOW   = uflag_q;
  assign bus.oUFLOW_CNT   = cnt_q;

endmodule

// File: tb/tb_d8m_read_scheduler.sv
// Directed + randomized bench for d8m_read_scheduler on a shrunken raster,
// compared every cycle against a frame-position reference model.
module tb_d8m_read_scheduler;

  localparam int HA = 4, HF = 1, HS = 2, HB = 3;
  localparam int VA = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int M_IDLE = 0, M_WAIT = 1, M_RUN = 2, M_RESYNC = 3;

  logic VGA_CLK = 1'b0;
  logic RESET_N = 1'b0;
  d8m_read_scheduler_if bus ();

  d8m_read_scheduler #(
    .H_ACT (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACT (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .VGA_CLK (VGA_CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  int checks = 0;
  int errors = 0;
  int t, m_mode, m_cnt;
  bit m_read, m_fstart, m_uflag;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic int cur_h();
    return t % HT;
  endfunction

  function automatic int cur_v();
    return (t / HT) % VT;
  endfunction

  task automatic model_reset();
    t = 0; m_mode = M_IDLE; m_cnt = 0;
    m_read = 0; m_fstart = 0; m_uflag = 0;
  endtask

  // Advance the reference by one clock using the inputs seen at that edge.
  task automatic model_step();
    bit fe, uf, was_wait;
    fe = (cur_h() == HT - 1) && (cur_v() == VT - 1);
    uf = m_read && bus.iFIFO_EMPTY;
    was_wait = (m_mode == M_WAIT);
    if (!bus.iENABLE) m_mode = M_IDLE;
    else if (m_mode == M_IDLE) m_mode = M_WAIT;
    else if (m_mode == M_WAIT && fe && bus.iFRAME_RDY) m_mode = M_RUN;
    else if (m_mode == M_RUN && uf) m_mode = M_RESYNC;
    else if (m_mode == M_RESYNC && fe) m_mode = M_WAIT;
    m_fstart = was_wait && (m_mode == M_RUN);
    if (m_fstart) m_uflag = 0;
    if (uf) begin
      m_uflag = 1;
      if (m_cnt < 255) m_cnt++;
    end
    t++;
    m_read = (m_mode == M_RUN) && (cur_h() < HA) && (cur_v() < VA);
  endtask

  task automatic check_all();
    int h, v;
    h = cur_h(); v = cur_v();
    chk("oX", 32'(bus.oX), 32'(h));
    chk("oY", 32'(bus.oY), 32'(v));
    chk("VGA_HS", 32'(bus.VGA_HS), 32'(!(h >= HA + HF && h < HA + HF + HS)));
    chk("VGA_VS", 32'(bus.VGA_VS), 32'(!(v >= VA + VF && v < VA + VF + VS)));
    chk("READ_Request", 32'(bus.READ_Request), 32'(m_read));
    chk("oFRAME_START", 32'(bus.oFRAME_START), 32'(m_fstart));
    chk("oUNDERFLOW", 32'(bus.oUNDERFLOW), 32'(m_uflag));
    chk("oUFLOW_CNT", 32'(bus.oUFLOW_CNT), 32'(m_cnt));
  endtask

  task automatic cyc();
    @(posedge VGA_CLK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic goto_pos(input int x, input int y);
    for (int i = 0; i <= FRAME && !(cur_h() == x && cur_v() == y); i++) cyc();
    chk("goto_pos", 32'(cur_h() == x && cur_v() == y), 32'd1);
  endtask

  task automatic wait_frame_start(input int budget);
    for (int i = 0; i < budget && bus.oFRAME_START !== 1'b1; i++) cyc();
    chk("frame_start_seen", 32'(bus.oFRAME_START), 32'd1);
    chk("frame_start_x", 32'(bus.oX), 32'd0);
    chk("frame_start_y", 32'(bus.oY), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, 32'(bus.oX), 32'd0);
    chk({tag, "_y"}, 32'(bus.oY), 32'd0);
    chk({tag, "_hs"}, 32'(bus.VGA_HS), 32'd1);
    chk({tag, "_vs"}, 32'(bus.VGA_VS), 32'd1);
    chk({tag, "_rd"}, 32'(bus.READ_Request), 32'd0);
    chk({tag, "_fs"}, 32'(bus.oFRAME_START), 32'd0);
    chk({tag, "_uf"}, 32'(bus.oUNDERFLOW), 32'd0);
    chk({tag, "_cnt"}, 32'(bus.oUFLOW_CNT), 32'd0);
  endtask

  initial begin
    int n;
    model_reset();
    bus.iENABLE = 1'b0; bus.iFRAME_RDY = 1'b0; bus.iFIFO_EMPTY = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(negedge VGA_CLK);
    RESET_N = 1'b1;

    // Disabled: raster runs for two frames with no reads.
    n = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc();
      if (bus.READ_Request === 1'b1) n++;
    end
    chk("idle_reads", 32'(n), 32'd0);

    // Enable mid-frame; admission at the next frame boundary.
    goto_pos(5, 3);
    bus.iENABLE = 1'b1; bus.iFRAME_RDY = 1'b1;
    wait_frame_start(2 * FRAME);
    chk("first_read", 32'(bus.READ_Request), 32'd1);
    n = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (bus.READ_Request === 1'b1) n++;
      cyc();
    end
    chk("reads_per_frame", 32'(n), 32'(HA * VA));

    // Re-arm with RDY low: a whole frame is skipped.
    bus.iENABLE = 1'b0; cyc();
    bus.iENABLE = 1'b1; bus.iFRAME_RDY = 1'b0;
    n = 0;
    for (int i = 0; i < FRAME + 2; i++) begin
      cyc();
      if (bus.READ_Request === 1'b1) n++;
    end
    chk("skipped_reads", 32'(n), 32'd0);
    bus.iFRAME_RDY = 1'b1;
    wait_frame_start(2 * FRAME);

    // Single underflow inside the active area.
    goto_pos(2, 1);
    chk("pre_uf_read", 32'(bus.READ_Request), 32'd1);
    bus.iFIFO_EMPTY = 1'b1; cyc(); bus.iFIFO_EMPTY = 1'b0;
    chk("uf_read_drop", 32'(bus.READ_Request), 32'd0);
    chk("uf_flag", 32'(bus.oUNDERFLOW), 32'd1);
    chk("uf_cnt", 32'(bus.oUFLOW_CNT), 32'd1);
    wait_frame_start(3 * FRAME);
    chk("uf_flag_clear", 32'(bus.oUNDERFLOW), 32'd0);
    chk("uf_resume_read", 32'(bus.READ_Request), 32'd1);

    // Randomized enable/ready/empty traffic.
    for (int i = 0; i < 2000; i++) begin
      bus.iENABLE     = ($urandom_range(0, 199) != 0);
      bus.iFRAME_RDY  = ($urandom_range(0, 3) != 0);
      bus.iFIFO_EMPTY = ($urandom_range(0, 99) < 3);
      cyc();
    end

    // Permanent underflow for 300+ aborted frames saturates the counter.
    bus.iENABLE = 1'b1; bus.iFRAME_RDY = 1'b1; bus.iFIFO_EMPTY = 1'b1;
    run(620 * FRAME);
    chk("uf_saturate", 32'(bus.oUFLOW_CNT), 32'd255);
    bus.iFIFO_EMPTY = 1'b0;

    // Disable mid-active area, then reset asynchronously mid-line.
    wait_frame_start(3 * FRAME);
    goto_pos(HA / 2, VA / 2);
    chk("pre_dis_read", 32'(bus.READ_Request), 32'd1);
    bus.iENABLE = 1'b0; cyc();
    chk("dis_read_drop", 32'(bus.READ_Request), 32'd0);
    run(3);
    #2 RESET_N = 1'b0;
    #1 chk_reset_vals("async_rst");
    model_reset();
    @(negedge VGA_CLK);
    RESET_N = 1'b1;
    bus.iENABLE = 1'b1; bus.iFRAME_RDY = 1'b1;
    wait_frame_start(2 * FRAME);
    run(FRAME / 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
